// File: rtl/packet_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : packet_fifo_reader
// Description : Drains committed packets from a 9-bit packet FIFO (8-bit data
//               plus EOD tag) and streams them as valid/ready/last bytes to
//               the MAC transmit path. A frame is started only once the
//               writer has committed it in full, and a programmable
//               inter-frame gap is inserted after each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module packet_fifo_reader #(
   parameter int CNT_W      = 9,
   parameter int IFG_CYCLES = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pkt_commit,
   input  logic             fifo_empty,
   output logic             fifo_re,
   input  logic [7:0]       fifo_do,
   input  logic             fifo_eod,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   output logic             tx_last,
   input  logic             tx_ready,
   output logic             busy,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic             ovf_err
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam int               GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
   localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state;
   logic [GAP_W-1:0] gap_cnt;

   // Packets committed by the writer whose EOD byte has not yet been fetched
   logic [CNT_W-1:0] fetch_pend;
   logic [CNT_W-1:0] fetch_pend_nxt;
   logic [CNT_W-1:0] pkt_cnt_nxt;

   // A read accepted by the FIFO last cycle; its data is on fifo_do now
   logic             inflight;

   // Two-entry return buffer; the head entry drives the output stream
   logic             head_v;
   logic             head_eod;
   logic [7:0]       head_data;
   logic             tail_v;
   logic             tail_eod;
   logic [7:0]       tail_data;

   logic             ret_eod;
   logic             pop;
   logic             last_hs;
   logic [2:0]       credit;
   logic             fetch_left;

   // Output stream is driven straight from the head register
   assign tx_data  = head_data;
   assign tx_last  = head_eod;
   assign tx_valid = (state == SEND) & head_v;
   assign busy     = (state != IDLE);

   assign ret_eod  = inflight & fifo_eod;
   assign pop      = tx_valid & tx_ready;
   assign last_hs  = pop & head_eod;

   // Buffer entries still claimed after this cycle: stored plus returning minus leaving
   assign credit   = {2'b00, head_v} + {2'b00, tail_v} + {2'b00, inflight} - {2'b00, pop};

   // Only fetch while a committed packet still has bytes left in the FIFO;
   // an EOD returning this cycle closes one packet before the next read is issued
   assign fetch_left = (fetch_pend > {{(CNT_W-1){1'b0}}, ret_eod});

   // Read request: data present, a committed packet still unfetched, buffer credit left
   assign fifo_re  = ~fifo_empty & fetch_left & (credit < 3'd2);

   // Next values of both packet counters, saturating at the counter maximum
   always_comb begin
      pkt_cnt_nxt    = pkt_cnt;
      fetch_pend_nxt = fetch_pend;
      case ({pkt_commit, last_hs})
         2'b10:   if (pkt_cnt != CNT_MAX) pkt_cnt_nxt = pkt_cnt + CNT_ONE;
         2'b01:   if (pkt_cnt != '0)      pkt_cnt_nxt = pkt_cnt - CNT_ONE;
         default: pkt_cnt_nxt = pkt_cnt;
      endcase
      case ({pkt_commit, ret_eod})
         2'b10:   if (fetch_pend != CNT_MAX) fetch_pend_nxt = fetch_pend + CNT_ONE;
         2'b01:   if (fetch_pend != '0)      fetch_pend_nxt = fetch_pend - CNT_ONE;
         default: fetch_pend_nxt = fetch_pend;
      endcase
   end

   // Counter registers and the sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt    <= '0;
         fetch_pend <= '0;
         ovf_err    <= 1'b0;
      end else begin
         pkt_cnt    <= pkt_cnt_nxt;
         fetch_pend <= fetch_pend_nxt;
         if (pkt_commit && (pkt_cnt == CNT_MAX)) begin
            ovf_err <= 1'b1;
         end
      end
   end

   // Track the read the FIFO accepted so its data is captured next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_re;
      end
   end

   // Return buffer: returned words enter behind the head, output handshakes retire the head
   always_ff @(posedge clk) begin
      if (rst) begin
         head_v    <= 1'b0;
         head_eod  <= 1'b0;
         head_data <= 8'h00;
         tail_v    <= 1'b0;
         tail_eod  <= 1'b0;
         tail_data <= 8'h00;
      end else begin
         case ({inflight, pop})
            2'b01: begin
               head_v    <= tail_v;
               head_eod  <= tail_eod;
               head_data <= tail_data;
               tail_v    <= 1'b0;
            end
            2'b10: begin
               if (!head_v) begin
                  head_v    <= 1'b1;
                  head_eod  <= fifo_eod;
                  head_data <= fifo_do;
               end else begin
                  tail_v    <= 1'b1;
                  tail_eod  <= fifo_eod;
                  tail_data <= fifo_do;
               end
            end
            2'b11: begin
               if (tail_v) begin
                  head_eod  <= tail_eod;
                  head_data <= tail_data;
                  tail_eod  <= fifo_eod;
                  tail_data <= fifo_do;
               end else begin
                  head_eod  <= fifo_eod;
                  head_data <= fifo_do;
               end
            end
            default: begin
               head_v <= head_v;
            end
         endcase
      end
   end

   // Frame sequencer. Leaving the gap (or a zero-gap frame end) goes straight to
   // SEND when another frame is committed, so its first beat can land on the
   // first cycle after the gap rather than one cycle later via IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gap_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pkt_cnt_nxt != '0) begin
                  state <= SEND;
               end
            end
            SEND: begin
               if (last_hs) begin
                  if (IFG_CYCLES > 0) begin
                     state   <= GAP;
                     gap_cnt <= GAP_LOAD;
                  end else if (pkt_cnt_nxt == '0) begin
                     state <= IDLE;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state <= (pkt_cnt_nxt != '0) ? SEND : IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GAP_ONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_packet_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_packet_fifo_reader
// Description : Directed/randomised bench for packet_fifo_reader with a
//               byte-stream scoreboard and a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_fifo_reader;

   localparam int IFG = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pkt_commit = 1'b0;
   logic       fifo_empty = 1'b1;
   logic       fifo_re;
   logic [7:0] fifo_do = 8'h00;
   logic       fifo_eod = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready = 1'b1;
   logic       busy;
   logic [8:0] pkt_cnt;
   logic       ovf_err;

   // Second instance: narrow counters, FIFO never has data
   logic       commit2 = 1'b0;
   logic       empty2 = 1'b1;
   logic       re2;
   logic [7:0] do2 = 8'h00;
   logic       eod2 = 1'b0;
   logic [7:0] data2;
   logic       valid2;
   logic       last2;
   logic       ready2 = 1'b1;
   logic       busy2;
   logic [1:0] pkt_cnt2;
   logic       ovf2;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit rnd_ready = 1'b0;

   // Byte stream in write order: the FIFO contents and the expected output
   logic [8:0] stream [0:4095];
   int wr_ptr  = 0;
   int rd_ptr  = 0;
   int mon_ptr = 0;

   int npk = 0;
   int beat = 0;
   int last_cyc = -1000;
   int pkt_first [0:31];
   int pkt_last  [0:31];
   logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_rst = 1'b1;
   logic [7:0] prev_d = 8'h00;

   packet_fifo_reader #(.CNT_W(9), .IFG_CYCLES(IFG)) dut (
      .clk(clk), .rst(rst), .pkt_commit(pkt_commit), .fifo_empty(fifo_empty),
      .fifo_re(fifo_re), .fifo_do(fifo_do), .fifo_eod(fifo_eod),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_ready(tx_ready), .busy(busy), .pkt_cnt(pkt_cnt), .ovf_err(ovf_err)
   );

   packet_fifo_reader #(.CNT_W(2), .IFG_CYCLES(0)) dut2 (
      .clk(clk), .rst(rst), .pkt_commit(commit2), .fifo_empty(empty2),
      .fifo_re(re2), .fifo_do(do2), .fifo_eod(eod2),
      .tx_data(data2), .tx_valid(valid2), .tx_last(last2),
      .tx_ready(ready2), .busy(busy2), .pkt_cnt(pkt_cnt2), .ovf_err(ovf2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // FIFO model: read data one cycle after an accepted read; reset drops contents
   always @(posedge clk) begin
      if (rst) begin
         rd_ptr = wr_ptr;
         fifo_empty <= 1'b1;
         fifo_do    <= 8'h00;
         fifo_eod   <= 1'b0;
      end else begin
         if (fifo_re && (rd_ptr != wr_ptr)) begin
            {fifo_eod, fifo_do} <= stream[rd_ptr];
            rd_ptr = rd_ptr + 1;
         end
         fifo_empty <= (rd_ptr == wr_ptr);
      end
   end

   // Output monitor: scoreboard, stall hold, no bubbles, inter-frame gap
   always @(negedge clk) begin
      if (rst) begin
         mon_ptr  = wr_ptr;
         beat     = 0;
         last_cyc = -1000;
         prev_v   = 1'b0;
         prev_rst = 1'b1;
      end else begin
         if (!prev_rst && prev_v && !prev_r)
            chk("stall_hold", {22'd0, tx_valid, tx_last, tx_data}, {22'd0, 1'b1, prev_l, prev_d});
         if (!prev_rst && prev_v && prev_r && !prev_l)
            chk("no_bubble", {31'd0, tx_valid}, 32'd1);
         if ((cyc - last_cyc) <= IFG)
            chk("ifg_idle", {31'd0, tx_valid}, 32'd0);
         if (tx_valid && tx_ready) begin
            chk("beat_pending", {31'd0, (mon_ptr < wr_ptr)}, 32'd1);
            if (mon_ptr < wr_ptr) begin
               chk("beat_data", {22'd0, tx_last, tx_data}, {23'd0, stream[mon_ptr]});
               mon_ptr++;
            end
            if (beat == 0 && npk < 32) pkt_first[npk] = cyc;
            beat++;
            if (tx_last) begin
               if (npk < 32) pkt_last[npk] = cyc;
               last_cyc = cyc;
               npk++;
               beat = 0;
            end
         end
         prev_v   = tx_valid;
         prev_r   = tx_ready;
         prev_l   = tx_last;
         prev_d   = tx_data;
         prev_rst = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic push_bytes(input int n, input bit end_pkt);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom_range(0, 255));
         stream[wr_ptr] = {(end_pkt && (i == n - 1)), b};
         wr_ptr++;
      end
   endtask

   task automatic commit_pulse();
      pkt_commit = 1'b1;
      step();
      pkt_commit = 1'b0;
   endtask

   task automatic wait_pkts(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && npk < target; i++) step();
      chk(tag, {31'd0, (npk >= target)}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_fifo_re"},  {31'd0, fifo_re},  32'd0);
      chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
      chk({tag, "_tx_last"},  {31'd0, tx_last},  32'd0);
      chk({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
      chk({tag, "_busy"},     {31'd0, busy},     32'd0);
      chk({tag, "_pkt_cnt"},  {23'd0, pkt_cnt},  32'd0);
      chk({tag, "_ovf_err"},  {31'd0, ovf_err},  32'd0);
      chk({tag, "_ovf2"},     {31'd0, ovf2},     32'd0);
      chk({tag, "_pkt_cnt2"}, {30'd0, pkt_cnt2}, 32'd0);
   endtask

   initial begin
      int  n0;
      int  t0;
      bit  saw;
      bit  found;

      // Reset
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      check_reset_outputs("reset");

      // Single 64-byte packet: latency 3, contiguous beats, counter back to 0
      n0 = npk;
      push_bytes(64, 1'b1);
      t0 = cyc;
      commit_pulse();
      chk("t1_pkt_cnt_one", {23'd0, pkt_cnt}, 32'd1);
      chk("t1_busy",        {31'd0, busy},    32'd1);
      chk("t1_fifo_re",     {31'd0, fifo_re}, 32'd1);
      for (int i = 0; i < 20 && !tx_valid; i++) step();
      chk("t1_valid_seen", {31'd0, tx_valid}, 32'd1);
      chk("t1_latency", cyc - t0, 32'd3);
      wait_pkts(n0 + 1, 400, "t1_done");
      chk("t1_contig", pkt_last[n0] - pkt_first[n0], 32'd63);
      chk("t1_pkt_cnt_zero", {23'd0, pkt_cnt}, 32'd0);

      // Two 60-byte packets back to back: exact gap, intact boundary
      n0 = npk;
      push_bytes(60, 1'b1);
      push_bytes(60, 1'b1);
      pkt_commit = 1'b1;
      step();
      step();
      pkt_commit = 1'b0;
      wait_pkts(n0 + 2, 600, "t2_done");
      chk("t2_gap", pkt_first[n0 + 1] - pkt_last[n0], 32'(IFG + 1));
      chk("t2_contig0", pkt_last[n0] - pkt_first[n0], 32'd59);
      chk("t2_contig1", pkt_last[n0 + 1] - pkt_first[n0 + 1], 32'd59);

      // Second packet partly written and not committed: must not start
      n0 = npk;
      push_bytes(20, 1'b1);
      push_bytes(5, 1'b0);
      commit_pulse();
      wait_pkts(n0 + 1, 200, "t3_first_done");
      saw = 1'b0;
      repeat (30) begin
         step();
         saw |= tx_valid;
      end
      chk("t3_hold_uncommitted", {31'd0, saw}, 32'd0);
      chk("t3_idle", {31'd0, busy}, 32'd0);
      push_bytes(10, 1'b1);
      commit_pulse();
      wait_pkts(n0 + 2, 200, "t3_second_done");
      chk("t3_contig", pkt_last[n0 + 1] - pkt_first[n0 + 1], 32'd14);

      // 1500-byte packet with random back-pressure
      n0 = npk;
      rnd_ready = 1'b1;
      push_bytes(1500, 1'b1);
      commit_pulse();
      wait_pkts(n0 + 1, 8000, "t4_done");
      rnd_ready = 1'b0;
      step();
      chk("t4_all_bytes", mon_ptr, wr_ptr);
      chk("t4_fetch_pend", {23'd0, dut.fetch_pend}, 32'd0);
      chk("t4_pkt_cnt", {23'd0, pkt_cnt}, 32'd0);

      // Commit coinciding with the last handshake while pkt_cnt=1
      n0 = npk;
      push_bytes(8, 1'b1);
      push_bytes(6, 1'b1);
      commit_pulse();
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (tx_valid && tx_last && tx_ready) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("t5_last_seen", {31'd0, found}, 32'd1);
      pkt_commit = 1'b1;
      step();
      pkt_commit = 1'b0;
      chk("t5_pkt_cnt_hold", {23'd0, pkt_cnt}, 32'd1);
      wait_pkts(n0 + 2, 200, "t5_done");

      // Overflow on the narrow-counter instance
      for (int i = 0; i < 3; i++) begin
         commit2 = 1'b1;
         step();
         commit2 = 1'b0;
         step();
      end
      chk("t6_cnt_full", {30'd0, pkt_cnt2}, 32'd3);
      chk("t6_no_ovf",   {31'd0, ovf2},     32'd0);
      commit2 = 1'b1;
      step();
      commit2 = 1'b0;
      chk("t6_ovf_set",  {31'd0, ovf2},     32'd1);
      chk("t6_cnt_sat",  {30'd0, pkt_cnt2}, 32'd3);
      repeat (5) step();
      chk("t6_ovf_sticky", {31'd0, ovf2}, 32'd1);

      // Reset in the middle of a packet, then a fresh packet
      push_bytes(30, 1'b1);
      commit_pulse();
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (beat >= 10) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("t7_mid_packet", {31'd0, found}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_outputs("t7_rst");
      n0 = npk;
      push_bytes(16, 1'b1);
      commit_pulse();
      wait_pkts(n0 + 1, 200, "t7_after_rst_done");
      chk("t7_contig", pkt_last[n0] - pkt_first[n0], 32'd15);

      repeat (5) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
